pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, width of the PC and instruction fields.
REQ-002 SHALL provide parameter NOP, default 32'h0000_0013, instruction value driven while the stage holds no valid entry.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held entries.
REQ-007 in_valid  input  1  upstream offers an entry.
REQ-008 in_ready  output  1  stage can accept an entry; registered, no combinational path from out_ready.
REQ-009 in_pc, in_instr  input  WIDTH each  upstream payload.
REQ-010 out_valid  output  1  stage presents an entry.
REQ-011 out_ready  input  1  downstream accepts the entry.
REQ-012 out_pc, out_instr  output  WIDTH each  downstream payload.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  present only with PIPE_STAGE_CNT_EN.

Function
REQ-014 Transfer SHALL occur on an interface only when valid and ready are both high at a rising edge.
REQ-015 Storage SHALL be a main register and one skid register; FSM states are EMPTY (0 entries), BUSY (main only), FULL (main and skid).
REQ-016 Outputs SHALL be: out_valid=1 in BUSY/FULL; out_pc/out_instr from main; in_ready=1 in EMPTY/BUSY and 0 in FULL.
REQ-017 EMPTY with an input transfer SHALL go to BUSY and load main; latency input-to-output is 1 cycle.
REQ-018 BUSY with input and output transfers together SHALL reload main and stay in BUSY, giving one transfer per cycle at full throughput.
REQ-019 BUSY with input transfer and no output transfer SHALL load skid and go to FULL.
REQ-020 BUSY with output transfer only SHALL go to EMPTY.
REQ-021 FULL with output transfer SHALL move skid into main and go to BUSY; no input transfer is possible in FULL.
REQ-022 Entry order SHALL be preserved; no entry is duplicated or lost except by flush.
REQ-023 When out_valid=0, out_instr SHALL equal NOP and out_pc SHALL equal 0.
REQ-024 While out_valid=1 and out_ready=0, out_pc/out_instr SHALL remain stable.
REQ-025 flush=1 SHALL force EMPTY at the next edge, discarding main, skid and any simultaneous input transfer; an output transfer in the same cycle still completes downstream.

Reset
REQ-026 While rst=0 at an edge, the stage SHALL enter EMPTY, clear main and skid to 0 and clear counters; after the edge out_valid=0, out_pc=0, out_instr=NOP, in_ready=1.
REQ-027 Reset SHALL take priority over flush and all transfers, including when asserted mid-stall in FULL.
REQ-028 Inputs offered while rst=0 SHALL be ignored.

Configuration
REQ-029 With macro PIPE_STAGE_CNT_EN defined: stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0; flush_cnt SHALL increment each cycle with flush=1; both saturate at all-ones.
REQ-030 Without PIPE_STAGE_CNT_EN: ports stall_cnt/flush_cnt and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset: rst=0 one cycle -> out_valid=0, out_instr=32'h13, out_pc=0, in_ready=1.
REQ-032 Streaming: PCs 0x0,0x4,0x8 back-to-back with out_ready=1 -> emerge 1 cycle later in order, in_ready stays 1.
REQ-033 Backpressure: out_ready=0 while sending 0x100,0x104 -> FULL, in_ready=0, out_pc holds 0x100; release -> 0x100 then 0x104, no loss.
REQ-034 Flush: in FULL, assert flush with in_valid=1 (0x200) -> next cycle EMPTY, out_instr=NOP, 0x200 never appears.
REQ-035 Reset mid-stall: FULL with out_ready=0, pulse rst=0 -> EMPTY, counters 0.
REQ-036 Counters (CNT_EN): hold out_ready=0 for 5 cycles with a valid entry, then flush 2 cycles -> stall_cnt=5, flush_cnt=2; CNT_W=2 with 6 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one-entry pipeline register with a skid slot so that in_ready
// is derived purely from registered state (no combinational path from out_ready).
// Latency: 1 cycle input-to-output; full throughput of one transfer per cycle.
// Backpressure: when out_ready drops, one extra entry lands in skid and in_ready falls.
// Ports: clk, rst (sync, active-low), flush;
//        in_valid/in_ready/in_pc/in_instr (upstream), out_valid/out_ready/out_pc/out_instr (downstream);
//        stall_cnt/flush_cnt exist only when macro PIPE_STAGE_CNT_EN is defined.
module pipe_skid_stage #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
`ifdef PIPE_STAGE_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_pc;
  logic [WIDTH-1:0] r_main_instr;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_instr;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_nop;

  assign w_nop      = WIDTH'(NOP);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transfer-driven move
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_in_xfer) w_state_nxt = BUSY;
        BUSY: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_xfer) w_state_nxt = BUSY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    out_valid = (r_state == BUSY) || (r_state == FULL);
    in_ready  = (r_state != FULL);
    out_pc    = out_valid ? r_main_pc    : '0;
    out_instr = out_valid ? r_main_instr : w_nop;
  end

  // Payload storage. Main is only rewritten when its current entry leaves
  // (or there is none), so it holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_pc    <= '0;
      r_main_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else if (flush) begin
      r_main_pc    <= '0;
      r_main_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
          end
        end
        BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
          end else if (w_in_xfer) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_STAGE_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks;
  int failures;

`ifdef PIPE_STAGE_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  stall_cnt2;
  logic [1:0]  flush_cnt2;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;
`endif

  pipe_skid_stage #(.WIDTH(32), .NOP(32'h0000_0013), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef PIPE_STAGE_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

`ifdef PIPE_STAGE_CNT_EN
  pipe_skid_stage #(.WIDTH(32), .NOP(32'h0000_0013), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_pc    (out_pc2),
    .out_instr (out_instr2),
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_instr  = 32'h0;
    out_ready = 1'b0;

    // Reset
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc",    out_pc,    32'h0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'h1);
    rst = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1; in_pc = 32'h0; in_instr = 32'hA000_0000;
    step();
    chk("strm0_valid", {31'b0, out_valid}, 32'h1);
    chk("strm0_pc",    out_pc,    32'h0);
    chk("strm0_instr", out_instr, 32'hA000_0000);
    chk("strm0_rdy",   {31'b0, in_ready}, 32'h1);
    in_pc = 32'h4; in_instr = 32'hA000_0004;
    step();
    chk("strm1_pc",  out_pc, 32'h4);
    chk("strm1_rdy", {31'b0, in_ready}, 32'h1);
    in_pc = 32'h8; in_instr = 32'hA000_0008;
    step();
    chk("strm2_pc",    out_pc,    32'h8);
    chk("strm2_instr", out_instr, 32'hA000_0008);
    chk("strm2_rdy",   {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
    step();
    chk("strm_drain_valid", {31'b0, out_valid}, 32'h0);
    chk("strm_drain_instr", out_instr, 32'h13);

    // Backpressure into FULL, then release
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h100; in_instr = 32'hB000_0100;
    step();
    chk("bp_busy_pc",  out_pc, 32'h100);
    chk("bp_busy_rdy", {31'b0, in_ready}, 32'h1);
    in_pc = 32'h104; in_instr = 32'hB000_0104;
    step();
    chk("bp_full_rdy", {31'b0, in_ready}, 32'h0);
    chk("bp_full_pc",  out_pc, 32'h100);
    in_pc = 32'h108; in_instr = 32'hB000_0108;   // not accepted: in_ready=0
    step();
    chk("bp_hold_pc",    out_pc,    32'h100);
    chk("bp_hold_instr", out_instr, 32'hB000_0100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_rel_pc",  out_pc, 32'h104);
    chk("bp_rel_rdy", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_empty_valid", {31'b0, out_valid}, 32'h0);

    // Flush from FULL with a simultaneous offer
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h300; in_instr = 32'hC000_0300;
    step();
    in_pc = 32'h304; in_instr = 32'hC000_0304;
    step();
    chk("fl_full_rdy", {31'b0, in_ready}, 32'h0);
    flush = 1'b1;
    in_pc = 32'h200; in_instr = 32'hD000_0200;
    step();
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_instr", out_instr, 32'h13);
    chk("fl_pc",    out_pc,    32'h0);
    chk("fl_rdy",   {31'b0, in_ready}, 32'h1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_after_valid", {31'b0, out_valid}, 32'h0);

    // Reset mid-stall in FULL, with an offer that must be ignored
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'hE000_0400;
    step();
    in_pc = 32'h404; in_instr = 32'hE000_0404;
    step();
    chk("rs_full_rdy", {31'b0, in_ready}, 32'h0);
    rst   = 1'b0;
    in_pc = 32'h500; in_instr = 32'hE000_0500;
    step();
    chk("rs_valid", {31'b0, out_valid}, 32'h0);
    chk("rs_rdy",   {31'b0, in_ready}, 32'h1);
    chk("rs_pc",    out_pc, 32'h0);
`ifdef PIPE_STAGE_CNT_EN
    chk("rs_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rs_flush_cnt", {16'b0, flush_cnt}, 32'h0);
`endif
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rs_after_valid", {31'b0, out_valid}, 32'h0);

    // One entry held under 5 stall cycles, then 2 flush cycles
    in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'hF000_0600;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("cn_hold_pc", out_pc, 32'h600);
`ifdef PIPE_STAGE_CNT_EN
    chk("cn_stall5",   {16'b0, stall_cnt}, 32'h5);
    chk("cn_stall_sat", {30'b0, stall_cnt2}, 32'h3);
`endif
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("cn_flush_valid", {31'b0, out_valid}, 32'h0);
`ifdef PIPE_STAGE_CNT_EN
    chk("cn_stall_final", {16'b0, stall_cnt}, 32'h5);
    chk("cn_flush2",      {16'b0, flush_cnt}, 32'h2);
    chk("cn_flush2_w2",   {30'b0, flush_cnt2}, 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
